// File: rtl/instruction_fetch_multi.sv
// rtl/instruction_fetch_multi.sv - variable-length instruction fetch, one memory word per request
// Word 0 carries the length field in its top LEN_W bits; later words fill data_out upward.
module instruction_fetch_multi #(
  parameter int ADDR_W    = 8,
  parameter int DATA_W    = 8,
  parameter int MAX_WORDS = 4,
  parameter int LEN_W     = 2
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic                          DIR,
  input  logic [ADDR_W-1:0]             data_in,
  output logic                          ack_prev,
  output logic                          DOR,
  input  logic                          ack_from_next,
  output logic [MAX_WORDS*DATA_W-1:0]   data_out,
  output logic [3:0]                    instr_len,
  output logic [ADDR_W-1:0]             instr_pc,
  output logic [ADDR_W-1:0]             next_pc,
  output logic                          len_err,
  output logic                          mem_en,
  output logic [ADDR_W-1:0]             mem_addr,
  output logic [DATA_W-1:0]             mem_di,
  input  logic [DATA_W-1:0]             mem_do,
  input  logic                          mem_do_ack
);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] REQ  = 2'd1;
  localparam logic [1:0] STEP = 2'd2;
  localparam logic [1:0] HOLD = 2'd3;

  logic [1:0]   state;
  logic [3:0]   cnt;
  logic [3:0]   tgt_len;
  logic [LEN_W:0] field_len;
  logic [3:0]   cur_len;
  logic         clip;
  logic         last_word;

  assign mem_di = '0;

  // The length is only known while word 0 is on mem_do, so decode it live on that word.
  always_comb begin
    field_len = {1'b0, mem_do[DATA_W-1 -: LEN_W]} + (LEN_W+1)'(1);
    clip      = 1'b0;
    cur_len   = tgt_len;
    if (cnt == 4'd0) begin
      if (int'(field_len) > MAX_WORDS) begin
        clip    = 1'b1;
        cur_len = 4'(MAX_WORDS);
      end else begin
        cur_len = 4'(field_len);
      end
    end
    last_word = ((cnt + 4'd1) == cur_len);
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state     <= IDLE;
      DOR       <= 1'b0;
      ack_prev  <= 1'b0;
      mem_en    <= 1'b0;
      mem_addr  <= '0;
      data_out  <= '0;
      instr_len <= '0;
      instr_pc  <= '0;
      next_pc   <= '0;
      len_err   <= 1'b0;
      cnt       <= '0;
      tgt_len   <= '0;
    end else begin
      ack_prev <= 1'b0;
      case (state)
        IDLE: begin
          DOR    <= 1'b0;
          mem_en <= 1'b0;
          if (DIR) begin
            ack_prev <= 1'b1;
            mem_addr <= data_in;
            instr_pc <= data_in;
            mem_en   <= 1'b1;
            cnt      <= '0;
            data_out <= '0;
            len_err  <= 1'b0;
            state    <= REQ;
          end
        end
        REQ: begin
          if (mem_do_ack) begin
            for (int i = 0; i < MAX_WORDS; i++) begin
              if (int'(cnt) == i) data_out[i*DATA_W +: DATA_W] <= mem_do;
            end
            if (cnt == 4'd0) begin
              tgt_len <= cur_len;
              if (clip) len_err <= 1'b1;
            end
            mem_en <= 1'b0;
            if (last_word) begin
              instr_len <= cur_len;
              next_pc   <= instr_pc + ADDR_W'(cur_len);
              DOR       <= 1'b1;
              state     <= HOLD;
            end else begin
              mem_addr <= mem_addr + ADDR_W'(1);
              cnt      <= cnt + 4'd1;
              state    <= STEP;
            end
          end
        end
        // One idle cycle between word requests gives the memory a clean request edge.
        STEP: begin
          mem_en <= 1'b1;
          state  <= REQ;
        end
        HOLD: begin
          if (ack_from_next) begin
            DOR   <= 1'b0;
            state <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_instruction_fetch_multi.sv
// tb/tb_instruction_fetch_multi.sv - bench for instruction_fetch_multi
// Lane 0 uses MAX_WORDS=4, lane 1 uses MAX_WORDS=3 so length clipping can be exercised.
module tb_instruction_fetch_multi;

  logic clk = 1'b0;
  logic reset;
  logic [1:0] dir, ackn, mem_ack;
  logic [1:0][7:0] din, mem_do;
  wire  [1:0] ack_prev, dor, len_err, mem_en;
  wire  [1:0][7:0] mem_addr, mem_di, instr_pc, next_pc;
  wire  [1:0][3:0] instr_len;
  wire  [31:0] data_out0;
  wire  [23:0] data_out1;

  logic [7:0] mem [256];
  int   mem_wait [2];
  bit   [1:0] mem_auto;
  int   waitc [2];
  int   nreq [2];
  int   nack [2];
  logic [7:0] req_q0 [$];
  int   gap_q0 [$];
  int   lowc0;
  logic [1:0] prev_en;
  int   checks = 0;
  int   errors = 0;

  always #5 clk = ~clk;

  instruction_fetch_multi #(.ADDR_W(8), .DATA_W(8), .MAX_WORDS(4), .LEN_W(2)) u_dut0 (
    .clk(clk), .reset(reset), .DIR(dir[0]), .data_in(din[0]), .ack_prev(ack_prev[0]),
    .DOR(dor[0]), .ack_from_next(ackn[0]), .data_out(data_out0), .instr_len(instr_len[0]),
    .instr_pc(instr_pc[0]), .next_pc(next_pc[0]), .len_err(len_err[0]), .mem_en(mem_en[0]),
    .mem_addr(mem_addr[0]), .mem_di(mem_di[0]), .mem_do(mem_do[0]), .mem_do_ack(mem_ack[0])
  );

  instruction_fetch_multi #(.ADDR_W(8), .DATA_W(8), .MAX_WORDS(3), .LEN_W(2)) u_dut1 (
    .clk(clk), .reset(reset), .DIR(dir[1]), .data_in(din[1]), .ack_prev(ack_prev[1]),
    .DOR(dor[1]), .ack_from_next(ackn[1]), .data_out(data_out1), .instr_len(instr_len[1]),
    .instr_pc(instr_pc[1]), .next_pc(next_pc[1]), .len_err(len_err[1]), .mem_en(mem_en[1]),
    .mem_addr(mem_addr[1]), .mem_di(mem_di[1]), .mem_do(mem_do[1]), .mem_do_ack(mem_ack[1])
  );

  // Request monitor plus a registered memory that answers mem_wait cycles after the minimum.
  always @(negedge clk) begin
    for (int i = 0; i < 2; i++) begin
      if (ack_prev[i]) nack[i]++;
      if (mem_en[i] && !prev_en[i]) begin
        nreq[i]++;
        if (i == 0) begin
          if (req_q0.size() > 0) gap_q0.push_back(lowc0);
          req_q0.push_back(mem_addr[0]);
        end
      end
      if (i == 0) begin
        if (mem_en[0]) lowc0 = 0;
        else lowc0++;
      end
      prev_en[i] = mem_en[i];
      if (mem_auto[i]) begin
        if (mem_ack[i]) begin
          mem_ack[i] = 1'b0;
          waitc[i]   = 0;
        end else if (mem_en[i]) begin
          if (waitc[i] >= mem_wait[i] + 1) begin
            mem_ack[i] = 1'b1;
            mem_do[i]  = mem[mem_addr[i]];
          end else begin
            waitc[i]++;
          end
        end
      end
    end
  end

  function automatic void ref_fetch(input logic [7:0] pc, input int maxw,
                                    output logic [31:0] data, output int len, output logic err);
    logic [7:0] w0;
    w0   = mem[pc];
    len  = int'(w0[7:6]) + 1;
    err  = 1'b0;
    if (len > maxw) begin
      len = maxw;
      err = 1'b1;
    end
    data = '0;
    for (int i = 0; i < len; i++) data[i*8 +: 8] = mem[8'(pc + 8'(i))];
  endfunction

  function automatic logic [31:0] dout(input int l);
    return (l == 1) ? {8'h00, data_out1} : data_out0;
  endfunction

  task automatic run_fetch(input int l, input logic [7:0] pc, output int lat, output bit ok);
    req_q0.delete();
    gap_q0.delete();
    nreq[l] = 0;
    nack[l] = 0;
    @(posedge clk);
    #1;
    dir[l] = 1'b1;
    din[l] = pc;
    lat = 0;
    ok  = 1'b0;
    for (int n = 0; n < 300; n++) begin
      @(negedge clk);
      lat++;
      if (ack_prev[l]) dir[l] = 1'b0;
      if (dor[l]) begin
        ok = 1'b1;
        break;
      end
    end
    dir[l] = 1'b0;
  endtask

  task automatic release_lane(input int l, input int hold, output logic d);
    repeat (hold) @(negedge clk);
    ackn[l] = 1'b1;
    @(negedge clk);
    ackn[l] = 1'b0;
    d = dor[l];
  endtask

  task automatic test_reset;
    reset = 1'b0;
    dir = '0; ackn = '0; mem_ack = '0; din = '0; mem_do = '0;
    repeat (3) @(negedge clk);
    for (int l = 0; l < 2; l++) begin
      checks++;
      if ({ack_prev[l], dor[l], len_err[l], mem_en[l]} !== 4'b0000) begin
        errors++;
        $display("FAIL reset_ctl lane%0d: got %b expected 0000", l, {ack_prev[l], dor[l], len_err[l], mem_en[l]});
      end
      checks++;
      if ({mem_addr[l], mem_di[l], instr_pc[l], next_pc[l], instr_len[l], dout(l)} !== 68'h0) begin
        errors++;
        $display("FAIL reset_data lane%0d: addr %h pc %h next %h len %0d data %h expected all 0",
                 l, mem_addr[l], instr_pc[l], next_pc[l], instr_len[l], dout(l));
      end
    end
    @(posedge clk);
    #1;
    reset = 1'b1;
    nreq[0] = 0; nreq[1] = 0;
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      checks++;
      if ({mem_en, dor, ack_prev} !== 6'b0 || data_out0 !== 32'h0) begin
        errors++;
        $display("FAIL idle_quiet cycle %0d: mem_en %b dor %b ack %b data %h expected 0", c, mem_en, dor, ack_prev, data_out0);
      end
    end
    checks++;
    if (nreq[0] + nreq[1] !== 0) begin
      errors++;
      $display("FAIL idle_noreq: got %0d requests expected 0", nreq[0] + nreq[1]);
    end
  endtask

  task automatic test_single;
    int lat; bit ok; logic d;
    mem[8'h10] = 8'h05;
    mem_wait[0] = 0;
    run_fetch(0, 8'h10, lat, ok);
    checks++;
    if (!ok) begin errors++; $display("FAIL single_timeout: DOR never rose"); end
    checks++;
    if (lat !== 4) begin errors++; $display("FAIL single_latency: got %0d expected 4", lat); end
    checks++;
    if (nack[0] !== 1) begin errors++; $display("FAIL single_ackprev: got %0d pulses expected 1", nack[0]); end
    checks++;
    if (req_q0.size() !== 1 || req_q0[0] !== 8'h10) begin
      errors++; $display("FAIL single_req: got %0d requests expected 1 at 10", req_q0.size());
    end
    checks++;
    if ({data_out0, instr_len[0], next_pc[0], instr_pc[0], len_err[0]} !== {32'h05, 4'd1, 8'h11, 8'h10, 1'b0}) begin
      errors++;
      $display("FAIL single_out: data %h len %0d next %h pc %h err %b expected 00000005 1 11 10 0",
               data_out0, instr_len[0], next_pc[0], instr_pc[0], len_err[0]);
    end
    release_lane(0, 0, d);
    checks++;
    if (d !== 1'b0) begin errors++; $display("FAIL single_release: DOR got %b expected 0", d); end
  endtask

  task automatic test_wrap;
    int lat; bit ok; logic d;
    mem[8'hFE] = 8'hC1; mem[8'hFF] = 8'hAA; mem[8'h00] = 8'hBB; mem[8'h01] = 8'hCC;
    mem_wait[0] = 2;
    run_fetch(0, 8'hFE, lat, ok);
    checks++;
    if (!ok) begin errors++; $display("FAIL wrap_timeout: DOR never rose"); end
    checks++;
    if (req_q0.size() !== 4 || req_q0[0] !== 8'hFE || req_q0[1] !== 8'hFF || req_q0[2] !== 8'h00 || req_q0[3] !== 8'h01) begin
      errors++; $display("FAIL wrap_addr: got %0d requests %p expected FE FF 00 01", req_q0.size(), req_q0);
    end
    checks++;
    if (gap_q0.size() !== 3 || gap_q0[0] !== 1 || gap_q0[1] !== 1 || gap_q0[2] !== 1) begin
      errors++; $display("FAIL wrap_gap: got %p expected three gaps of 1", gap_q0);
    end
    checks++;
    if ({data_out0, instr_len[0], next_pc[0], len_err[0]} !== {32'hCCBBAAC1, 4'd4, 8'h02, 1'b0}) begin
      errors++;
      $display("FAIL wrap_out: data %h len %0d next %h err %b expected CCBBAAC1 4 02 0",
               data_out0, instr_len[0], next_pc[0], len_err[0]);
    end
    release_lane(0, 1, d);
    checks++;
    if (d !== 1'b0) begin errors++; $display("FAIL wrap_release: DOR got %b expected 0", d); end
  endtask

  task automatic test_clip;
    int lat; bit ok; logic d;
    mem[8'h40] = 8'hC0; mem[8'h41] = 8'h11; mem[8'h42] = 8'h22; mem[8'h43] = 8'h33;
    mem_wait[1] = 0;
    run_fetch(1, 8'h40, lat, ok);
    checks++;
    if (!ok || nreq[1] !== 3) begin errors++; $display("FAIL clip_reads: got %0d reads ok %b expected 3", nreq[1], ok); end
    checks++;
    if ({data_out1, instr_len[1], next_pc[1], len_err[1]} !== {24'h2211C0, 4'd3, 8'h43, 1'b1}) begin
      errors++;
      $display("FAIL clip_out: data %h len %0d next %h err %b expected 2211C0 3 43 1",
               data_out1, instr_len[1], next_pc[1], len_err[1]);
    end
    release_lane(1, 0, d);
    checks++;
    if (d !== 1'b0) begin errors++; $display("FAIL clip_release: DOR got %b expected 0", d); end
  endtask

  task automatic test_hold;
    int lat, len, n0; bit ok; logic d, err; logic [31:0] exp;
    logic [7:0] pc;
    pc = 8'h80;
    for (int i = 0; i < 4; i++) mem[8'(pc + 8'(i))] = 8'($urandom);
    mem[pc] = {2'b10, 6'($urandom)};
    mem_wait[0] = 0;
    ref_fetch(pc, 4, exp, len, err);
    run_fetch(0, pc, lat, ok);
    n0 = nreq[0];
    mem_auto[0] = 1'b0;
    for (int c = 0; c < 10; c++) begin
      @(negedge clk);
      checks++;
      if ({ok, dor[0], mem_en[0], ack_prev[0], data_out0, instr_len[0], next_pc[0], len_err[0]} !==
          {1'b1, 1'b1, 1'b0, 1'b0, exp, 4'(len), 8'(pc + 8'(len)), err}) begin
        errors++;
        $display("FAIL hold_stable cycle %0d: dor %b en %b ack %b data %h len %0d next %h expected 1 0 0 %h %0d %h",
                 c, dor[0], mem_en[0], ack_prev[0], data_out0, instr_len[0], next_pc[0], exp, len, 8'(pc + 8'(len)));
      end
      dir[0] = 1'($urandom); din[0] = 8'($urandom);
      mem_ack[0] = 1'($urandom); mem_do[0] = 8'($urandom);
    end
    @(negedge clk);
    dir[0] = 1'b0; mem_ack[0] = 1'b0; waitc[0] = 0; mem_auto[0] = 1'b1;
    checks++;
    if (nreq[0] !== n0) begin errors++; $display("FAIL hold_noreq: got %0d requests expected %0d", nreq[0], n0); end
    release_lane(0, 0, d);
    checks++;
    if (d !== 1'b0) begin errors++; $display("FAIL hold_release: DOR got %b expected 0", d); end
    mem[8'h90] = 8'h07;
    run_fetch(0, 8'h90, lat, ok);
    checks++;
    if (!ok || data_out0 !== 32'h07 || instr_pc[0] !== 8'h90 || next_pc[0] !== 8'h91) begin
      errors++; $display("FAIL hold_next: ok %b data %h pc %h next %h expected 1 00000007 90 91", ok, data_out0, instr_pc[0], next_pc[0]);
    end
    release_lane(0, 0, d);
  endtask

  task automatic test_reset_mid;
    int lat, len; bit ok, seen; logic d, err; logic [31:0] exp;
    logic [7:0] pc;
    pc = 8'h20;
    mem[pc] = 8'hC3;
    for (int i = 1; i < 4; i++) mem[8'(pc + 8'(i))] = 8'($urandom);
    mem_wait[0] = 1;
    @(posedge clk);
    #1;
    dir[0] = 1'b1; din[0] = pc; seen = 1'b0;
    for (int n = 0; n < 50; n++) begin
      @(negedge clk);
      if (ack_prev[0]) dir[0] = 1'b0;
      if (mem_en[0] && mem_addr[0] == 8'(pc + 8'd1)) begin
        seen = 1'b1;
        break;
      end
    end
    dir[0] = 1'b0;
    mem_auto[0] = 1'b0;
    reset = 1'b0;
    checks++;
    if (!seen) begin errors++; $display("FAIL rmid_reach: second word request got none expected one"); end
    @(negedge clk);
    checks++;
    if ({dor[0], mem_en[0], ack_prev[0], len_err[0], mem_addr[0], instr_pc[0], next_pc[0], instr_len[0], data_out0} !== 64'h0) begin
      errors++;
      $display("FAIL rmid_reset: dor %b en %b addr %h pc %h data %h expected all 0", dor[0], mem_en[0], mem_addr[0], instr_pc[0], data_out0);
    end
    reset = 1'b1; mem_ack[0] = 1'b1; mem_do[0] = 8'hEE;
    @(negedge clk);
    mem_ack[0] = 1'b0;
    checks++;
    if ({dor[0], mem_en[0], data_out0, instr_len[0]} !== 38'h0) begin
      errors++;
      $display("FAIL rmid_lateack: dor %b en %b data %h len %0d expected 0", dor[0], mem_en[0], data_out0, instr_len[0]);
    end
    waitc[0] = 0; mem_auto[0] = 1'b1;
    ref_fetch(pc, 4, exp, len, err);
    run_fetch(0, pc, lat, ok);
    checks++;
    if (!ok || data_out0 !== exp || instr_len[0] !== 4'(len) || next_pc[0] !== 8'(pc + 8'(len))) begin
      errors++; $display("FAIL rmid_refetch: ok %b data %h len %0d expected %h %0d", ok, data_out0, instr_len[0], exp, len);
    end
    release_lane(0, 0, d);
  endtask

  task automatic test_random;
    int lat, len, l, maxw; bit ok; logic d, err; logic [31:0] exp;
    logic [7:0] pc;
    for (int it = 0; it < 30; it++) begin
      l    = it % 2;
      maxw = (l == 1) ? 3 : 4;
      pc   = 8'($urandom);
      for (int i = 0; i < 4; i++) mem[8'(pc + 8'(i))] = 8'($urandom);
      mem_wait[l] = $urandom_range(0, 2);
      ref_fetch(pc, maxw, exp, len, err);
      run_fetch(l, pc, lat, ok);
      checks++;
      if (!ok || dout(l) !== exp || instr_len[l] !== 4'(len) || instr_pc[l] !== pc ||
          next_pc[l] !== 8'(pc + 8'(len)) || len_err[l] !== err || nack[l] !== 1 || nreq[l] !== len) begin
        errors++;
        $display("FAIL rand_out it %0d lane %0d: ok %b data %h len %0d pc %h next %h err %b reqs %0d expected %h %0d %h %h %b %0d",
                 it, l, ok, dout(l), instr_len[l], instr_pc[l], next_pc[l], len_err[l], nreq[l],
                 exp, len, pc, 8'(pc + 8'(len)), err, len);
      end
      if (l == 0) begin
        for (int i = 0; i < len; i++) begin
          checks++;
          if (req_q0.size() <= i || req_q0[i] !== 8'(pc + 8'(i)) || (i > 0 && gap_q0[i-1] !== 1)) begin
            errors++; $display("FAIL rand_seq it %0d word %0d: reqs %p gaps %p expected start %h", it, i, req_q0, gap_q0, pc);
          end
        end
      end
      release_lane(l, $urandom_range(0, 3), d);
      checks++;
      if (d !== 1'b0) begin errors++; $display("FAIL rand_release it %0d: DOR got %b expected 0", it, d); end
    end
  endtask

  initial begin
    mem_auto = 2'b11;
    prev_en = '0;
    lowc0 = 0;
    for (int i = 0; i < 2; i++) begin waitc[i] = 0; nreq[i] = 0; nack[i] = 0; mem_wait[i] = 0; end
    for (int i = 0; i < 256; i++) mem[i] = '0;
    test_reset;
    test_single;
    test_wrap;
    test_clip;
    test_hold;
    test_reset_mid;
    test_random;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
